// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// Entry bundle, FSM states and PC increment.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with push/pop/flush.
// Ports: push_i/data_i in, pop_i in, flush_i in, data_o/full_o/empty_o out.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  // A full FIFO still accepts a push when the head leaves this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, reads instruction memory and queues entries for decode.
// Ports: imem_addr/imem_rdata, redirect_*, out_* handshake, misalign_err.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         err_q, err_d;
  fetch_entry_t hold_q, hold_d;

  fetch_entry_t head;
  fetch_entry_t wr_data;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  // Redirect wins: flush, and neither push nor pop this cycle.
  assign pop  = !empty && out_ready && !redirect_valid;
  assign push = (state_q == RUN) && (!full || pop)
                && !redirect_valid;

  assign wr_data = '{pc: pc_q, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (wr_data),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    err_d  = err_q;
    hold_d = hold_q;
    if (redirect_valid) begin
      pc_d  = {redirect_pc[31:2], 2'b00};
      err_d = err_q | (redirect_pc[1:0] != 2'b00);
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
    // Remember the last delivered entry so out_* hold when empty.
    if (pop) begin
      hold_d = head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = !empty;
  assign out_pc       = empty ? hold_q.pc    : head.pc;
  assign out_instr    = empty ? hold_q.instr : head.instr;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit.
// Directed scenarios plus a randomized stream against a sequence model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic        w_misalign_err;

  logic [31:0] key;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata   = imem_addr ^ key;
  assign w_imem_rdata = w_imem_addr ^ key;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
  );

  instruction_fetch_unit #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (2)
  ) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (w_imem_addr),
    .imem_rdata     (w_imem_rdata),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_valid      (w_out_valid),
    .out_ready      (out_ready),
    .out_instr      (w_out_instr),
    .out_pc         (w_out_pc),
    .misalign_err   (w_misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en, input logic rdy);
    rst_n          = 1'b0;
    fetch_en       = en;
    out_ready      = rdy;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    key = 32'h0;
    do_reset(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_pc, out_instr, misalign_err} !== 66'h0) begin
      bad++;
      $display("FAIL reset_outs: got v=%b pc=%h i=%h e=%b want 0",
               out_valid, out_pc, out_instr, misalign_err);
    end
    total++;
    if (imem_addr !== 32'h0 || w_imem_addr !== 32'hFFFF_FFF8) begin
      bad++;
      $display("FAIL reset_addr: got %h/%h want 0/fffffff8",
               imem_addr, w_imem_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    key = 32'h0;
    do_reset(1'b1, 1'b1);
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_lat: got v=%b want 0", out_valid);
    end
    for (int k = 2; k < 8; k++) begin
      tick();
      e = 32'(4 * (k - 2));
      total++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, e, e}) begin
        bad++;
        $display("FAIL stream_k%0d: got v=%b pc=%h i=%h want pc=%h",
                 k, out_valid, out_pc, out_instr, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    key = 32'h0;
    do_reset(1'b1, 1'b1);
    tick();
    for (int k = 2; k < 5; k++) begin
      tick();
      e = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
      total++;
      if ({w_out_valid, w_out_pc, w_out_instr} !== {1'b1, e, e}) begin
        bad++;
        $display("FAIL wrap_k%0d: got v=%b pc=%h i=%h want %h",
                 k, w_out_valid, w_out_pc, w_out_instr, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    key = 32'h0;
    do_reset(1'b1, 1'b0);
    for (int k = 1; k < 7; k++) tick();
    total++;
    if ({out_valid, out_pc, imem_addr} !== {1'b1, 32'h0, 32'h8}) begin
      bad++;
      $display("FAIL stall_hold: got v=%b pc=%h addr=%h want 1/0/8",
               out_valid, out_pc, imem_addr);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick();
      e = 32'(4 * k);
      total++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, e, e}) begin
        bad++;
        $display("FAIL stall_rel%0d: got v=%b pc=%h want %h",
                 k, out_valid, out_pc, e);
      end
    end
  endtask

  task automatic test_redirect();
    key = 32'h5A00_0000;
    do_reset(1'b1, 1'b0);
    for (int k = 1; k < 5; k++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h100}) begin
      bad++;
      $display("FAIL redir_flush: got v=%b addr=%h want 0/100",
               out_valid, imem_addr);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({out_valid, out_pc, out_instr} !==
        {1'b1, 32'h100, 32'h100 ^ key}) begin
      bad++;
      $display("FAIL redir_first: got v=%b pc=%h i=%h want 100",
               out_valid, out_pc, out_instr);
    end
    tick();
    total++;
    if (out_pc !== 32'h104) begin
      bad++;
      $display("FAIL redir_next: got %h want 104", out_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({misalign_err, out_valid, imem_addr} !== {2'b10, 32'h100}) begin
      bad++;
      $display("FAIL misalign: got e=%b v=%b addr=%h want 1/0/100",
               misalign_err, out_valid, imem_addr);
    end
    tick();
    total++;
    if ({out_valid, out_pc} !== {1'b1, 32'h100}) begin
      bad++;
      $display("FAIL misalign_pc: got v=%b pc=%h want 100",
               out_valid, out_pc);
    end
    fetch_en = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (misalign_err !== 1'b1) begin
      bad++;
      $display("FAIL misalign_sticky: got %b want 1", misalign_err);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    total++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h40}) begin
      bad++;
      $display("FAIL idle_redir: got v=%b addr=%h want 0/40",
               out_valid, imem_addr);
    end
    fetch_en = 1'b1;
    tick();
    tick();
    total++;
    if ({out_valid, out_pc} !== {1'b1, 32'h40}) begin
      bad++;
      $display("FAIL idle_resume: got v=%b pc=%h want 40",
               out_valid, out_pc);
    end
  endtask

  task automatic test_async_reset();
    key = 32'h0;
    do_reset(1'b1, 1'b0);
    for (int k = 1; k < 5; k++) tick();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL arst_pre: got v=%b want 1", out_valid);
    end
    #2;
    rst_n    = 1'b0;
    fetch_en = 1'b0;
    #1;
    total++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h0}) begin
      bad++;
      $display("FAIL arst_now: got v=%b addr=%h want 0/0",
               out_valid, imem_addr);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    total++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h0}) begin
      bad++;
      $display("FAIL arst_idle: got v=%b addr=%h want 0/0",
               out_valid, imem_addr);
    end
    fetch_en = 1'b1;
    tick();
    tick();
    total++;
    if ({out_valid, out_pc} !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL arst_resume: got v=%b pc=%h want 1/0",
               out_valid, out_pc);
    end
  endtask

  // Model: decode sees the address sequence start, start+4, ...
  // restarting at the aligned target after every redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [31:0] st_pc;
    bit          err_m;
    bit          st_prev;
    bit          rd_prev;
    int          pops;
    bit          seen;
    key = $urandom;
    do_reset(1'b1, 1'b0);
    exp_pc  = 32'h0;
    err_m   = 1'b0;
    st_prev = 1'b0;
    rd_prev = 1'b0;
    st_pc   = '0;
    tgt     = '0;
    pops    = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      total++;
      if (misalign_err !== err_m) begin
        bad++;
        $display("FAIL rnd_err c%0d: got %b want %b",
                 i, misalign_err, err_m);
      end
      if (st_prev) begin
        total++;
        if ({out_valid, out_pc} !== {1'b1, st_pc}) begin
          bad++;
          $display("FAIL rnd_stable c%0d: got v=%b pc=%h want %h",
                   i, out_valid, out_pc, st_pc);
        end
      end
      if (rd_prev) begin
        total++;
        if ({out_valid, imem_addr} !== {1'b0, tgt}) begin
          bad++;
          $display("FAIL rnd_redir c%0d: got v=%b addr=%h want %h",
                   i, out_valid, imem_addr, tgt);
        end
      end
      out_ready      = ($urandom_range(0, 3) != 0);
      fetch_en       = ($urandom_range(0, 7) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom & 32'h0000_FFFF;
      rd_prev = redirect_valid;
      if (redirect_valid) begin
        tgt    = redirect_pc & ~32'h3;
        exp_pc = tgt;
        if (redirect_pc[1:0] != 2'b00) err_m = 1'b1;
      end else if (out_valid && out_ready) begin
        pops++;
        total++;
        if (out_pc !== exp_pc || out_instr !== (exp_pc ^ key)) begin
          bad++;
          $display("FAIL rnd_pop c%0d: got pc=%h i=%h want %h/%h",
                   i, out_pc, out_instr, exp_pc, exp_pc ^ key);
        end
        exp_pc = exp_pc + 32'd4;
      end
      st_prev = out_valid && !out_ready && !redirect_valid;
      st_pc   = out_pc;
    end
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = out_valid;
    end
    total++;
    if (!seen || out_pc !== exp_pc) begin
      bad++;
      $display("FAIL rnd_drain: got v=%b pc=%h want 1/%h",
               seen, out_pc, exp_pc);
    end
    total++;
    if (pops < 50) begin
      bad++;
      $display("FAIL rnd_rate: got %0d pops want >=50", pops);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    key            = '0;
    test_reset();
    test_stream();
    test_wrap();
    test_stall();
    test_redirect();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
